// File: rtl/rv32i_mem_pkg.sv
// Shared types and default widths for the unified instruction/data memory path.
package rv32i_mem_pkg;

    localparam int unsigned DEFAULT_AW = 32;
    localparam int unsigned DEFAULT_DW = 32;
    // Starvation counter width; STARVE_LIMIT must fit (1..15)
    localparam int unsigned STARVE_CW  = 4;

    // Which requester owns the read data returning next cycle
    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        DM   = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch waits.
module arb_starve_ctr #(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    input  logic [CW-1:0] limit,
    output logic          at_limit
);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear wins over increment; increment stops at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < limit)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-port synchronous-read memory between fetch and data
// ports, returns read data to its owner a cycle later, and sequences halt.
module unified_mem_arbiter
    import rv32i_mem_pkg::*;
#(
    parameter int unsigned AW           = DEFAULT_AW,
    parameter int unsigned DW           = DEFAULT_DW,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic            dm_gnt,
    output logic            dm_rvalid,
    output logic [DW-1:0]   dm_rdata,
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-3:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            halt,
    output logic            halt_ack,
    output logic [31:0]     stall_cycles
);

    halt_state_t state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [31:0] stall_q;
    logic        at_limit;
    logic        fetch_blocked;
    logic        starve_inc;
    logic        starve_clr;

    // Byte-offset bits are dropped on the word-addressed memory
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], dm_addr[1:0]};

    arb_starve_ctr #(
        .CW (STARVE_CW)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .limit    (STARVE_CW'(STARVE_LIMIT)),
        .at_limit (at_limit)
    );

    // Grant decision: data by default, fetch when data idle or fetch is starved.
    // Fetch is blocked from the cycle halt is first seen.
    always_comb begin
        fetch_blocked = (state_q != RUN) | halt;
        if_gnt        = if_req & ~fetch_blocked & (~dm_req | at_limit);
        dm_gnt        = dm_req & ~if_gnt;
        starve_inc    = dm_gnt & if_req;
        starve_clr    = if_gnt | ~if_req;
    end

    // Memory command follows the winner; all zero when idle
    always_comb begin
        mem_en    = if_gnt | dm_gnt;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_be   = '1;
            mem_addr = if_addr[AW-1:2];
        end else if (dm_gnt) begin
            mem_we    = dm_we;
            mem_be    = dm_be;
            mem_addr  = dm_addr[AW-1:2];
            mem_wdata = dm_wdata;
        end
    end

    // Tag the owner of the read data that returns next cycle; stores tag nothing
    always_comb begin
        owner_d = NONE;
        if (if_gnt) begin
            owner_d = IF;
        end else if (dm_gnt && !dm_we) begin
            owner_d = DM;
        end
    end

    // Owner tag register; reset discards any in-flight read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Steer returning read data to the tagged port
    always_comb begin
        if_rvalid = (owner_q == IF);
        dm_rvalid = (owner_q == DM);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
    end

    // Halt FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt FSM next state: drain waits only for an outstanding fetch read
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt) state_d = DRAIN;
            DRAIN:   if (owner_q != IF) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // Halt FSM output: acknowledged once no fetch data remains in flight
    always_comb begin
        halt_ack = (state_q == HALTED) || ((state_q == DRAIN) && (owner_q != IF));
    end

    // Fetch stall cycles while running, saturating
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if ((state_q == RUN) && if_req && !if_gnt && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized and directed bench for unified_mem_arbiter with a reference model.
module tb_unified_mem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LIM = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [31:0]   if_rdata;
    logic          dm_req = 1'b0, dm_we = 1'b0;
    logic [3:0]    dm_be = '0;
    logic [31:0]   dm_addr = '0, dm_wdata = '0;
    logic          dm_gnt, dm_rvalid;
    logic [31:0]   dm_rdata;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [29:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic          halt = 1'b0;
    logic          halt_ack;
    logic [31:0]   stall_cycles;

    unified_mem_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_be        (dm_be),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_gnt       (dm_gnt),
        .dm_rvalid    (dm_rvalid),
        .dm_rdata     (dm_rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .halt         (halt),
        .halt_ack     (halt_ack),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          consec;      // data grants in a row while fetch waits
    bit          halt_seen;   // halt observed in an earlier cycle
    int          pend;        // 0 nothing, 1 fetch data due, 2 load data due
    logic [31:0] exp_stall;
    logic        exp_if_gnt, exp_dm_gnt;
    logic        last_if_gnt, last_dm_gnt;

    // Observations captured at the check point of the most recent cycle
    logic        o_if_gnt, o_dm_gnt, o_if_rvalid, o_dm_rvalid, o_mem_we, o_halt_ack;
    logic [3:0]  o_mem_be;
    logic [29:0] o_mem_addr;
    logic [31:0] o_stall, o_if_rdata, o_dm_rdata, drv_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        consec      = 0;
        halt_seen   = 1'b0;
        pend        = 0;
        exp_stall   = '0;
        last_if_gnt = 1'b0;
        last_dm_gnt = 1'b0;
    endtask

    // Drop all inputs, pulse reset across one rising edge, check reset values
    task automatic do_reset();
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; halt = 1'b0;
        mem_rdata = 32'hA5A5_5A5A;
        rst = 1'b0;
        #2;
        chk("rst_if_gnt", 64'(if_gnt), 64'd0);
        chk("rst_dm_gnt", 64'(dm_gnt), 64'd0);
        chk("rst_if_rvalid", 64'(if_rvalid), 64'd0);
        chk("rst_dm_rvalid", 64'(dm_rvalid), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_dm_rdata", 64'(dm_rdata), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_halt_ack", 64'(halt_ack), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle: inputs already driven after a falling edge
    task automatic cycle();
        mem_rdata = $urandom;
        drv_rdata = mem_rdata;
        #2;
        exp_if_gnt = if_req && !(halt_seen || halt) && (!dm_req || consec == LIM);
        exp_dm_gnt = dm_req && !exp_if_gnt;
        o_if_gnt = if_gnt; o_dm_gnt = dm_gnt; o_if_rvalid = if_rvalid;
        o_dm_rvalid = dm_rvalid; o_mem_we = mem_we; o_halt_ack = halt_ack;
        o_mem_be = mem_be; o_mem_addr = mem_addr; o_stall = stall_cycles;
        o_if_rdata = if_rdata; o_dm_rdata = dm_rdata;
        chk("if_gnt", 64'(if_gnt), 64'(exp_if_gnt));
        chk("dm_gnt", 64'(dm_gnt), 64'(exp_dm_gnt));
        chk("mem_en", 64'(mem_en), 64'(exp_if_gnt || exp_dm_gnt));
        if (exp_if_gnt) begin
            chk("if_mem_addr", 64'(mem_addr), 64'(if_addr / 4));
            chk("if_mem_be", 64'(mem_be), 64'hF);
            chk("if_mem_we", 64'(mem_we), 64'd0);
        end else if (exp_dm_gnt) begin
            chk("dm_mem_addr", 64'(mem_addr), 64'(dm_addr / 4));
            chk("dm_mem_we", 64'(mem_we), 64'(dm_we));
            if (dm_we) begin
                chk("dm_mem_be", 64'(mem_be), 64'(dm_be));
                chk("dm_mem_wdata", 64'(mem_wdata), 64'(dm_wdata));
            end
        end else begin
            chk("idle_mem", 64'({mem_we, mem_be, mem_addr} != '0 || mem_wdata != '0), 64'd0);
        end
        chk("if_rvalid", 64'(if_rvalid), 64'(pend == 1));
        chk("dm_rvalid", 64'(dm_rvalid), 64'(pend == 2));
        if (pend == 1) chk("if_rdata", 64'(if_rdata), 64'(drv_rdata));
        if (pend == 2) chk("dm_rdata", 64'(dm_rdata), 64'(drv_rdata));
        chk("halt_ack", 64'(halt_ack), 64'(halt_seen));
        chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
        @(posedge clk);
        if (!halt_seen && if_req && !exp_if_gnt && exp_stall != 32'hFFFF_FFFF)
            exp_stall = exp_stall + 32'd1;
        if (if_req && exp_dm_gnt) consec = (consec < LIM) ? consec + 1 : LIM;
        else if (!if_req || exp_if_gnt) consec = 0;
        pend = exp_if_gnt ? 1 : ((exp_dm_gnt && !dm_we) ? 2 : 0);
        if (halt) halt_seen = 1'b1;
        last_if_gnt = exp_if_gnt;
        last_dm_gnt = exp_dm_gnt;
        @(negedge clk);
    endtask

    // New random request only once the previous one was accepted
    task automatic rand_drive();
        if (!if_req || last_if_gnt) begin
            if_req  = ($urandom_range(0, 2) != 0);
            if_addr = $urandom;
        end
        if (!dm_req || last_dm_gnt) begin
            dm_req   = ($urandom_range(0, 2) != 0);
            dm_we    = 1'($urandom_range(0, 1));
            dm_be    = 4'($urandom);
            dm_addr  = $urandom;
            dm_wdata = $urandom;
        end
    endtask

    initial begin
        #1;
        do_reset();

        // Lone fetch at 0x10
        if_req = 1'b1; if_addr = 32'h10;
        cycle();
        chk("t1_if_gnt", 64'(o_if_gnt), 64'd1);
        chk("t1_mem_addr", 64'(o_mem_addr), 64'h4);
        if_req = 1'b0;
        cycle();
        chk("t1_if_rvalid", 64'(o_if_rvalid), 64'd1);
        chk("t1_if_rdata", 64'(o_if_rdata), 64'(drv_rdata));

        // Contention for 10 cycles: D,D,D,D,I repeating
        if_req = 1'b1; if_addr = 32'h100;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t2_pattern", 64'(o_if_gnt), 64'(i % 5 == 4));
        end
        if_req = 1'b0; dm_req = 1'b0;
        cycle();
        chk("t2_stall", 64'(o_stall), 64'd8);

        // Store: no read data returned
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'h3; dm_addr = 32'h8; dm_wdata = 32'hDEAD_BEEF;
        cycle();
        chk("t3_mem_we", 64'(o_mem_we), 64'd1);
        chk("t3_mem_be", 64'(o_mem_be), 64'h3);
        chk("t3_mem_addr", 64'(o_mem_addr), 64'h2);
        dm_req = 1'b0; dm_we = 1'b0;
        cycle();
        chk("t3_no_rvalid", 64'(o_dm_rvalid), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rand_drive();
            cycle();
        end

        // Reset one cycle after a load grant discards the read
        if_req = 1'b0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
        cycle();
        chk("t5_dm_gnt", 64'(o_dm_gnt), 64'd1);
        do_reset();
        cycle();
        chk("t5_no_rvalid", 64'(o_dm_rvalid), 64'd0);

        // Halt after a fetch grant
        if_req = 1'b1; if_addr = 32'h40;
        cycle();
        chk("t4_if_gnt_n", 64'(o_if_gnt), 64'd1);
        if_addr = 32'h44; halt = 1'b1;
        cycle();
        chk("t4_rvalid_n1", 64'(o_if_rvalid), 64'd1);
        chk("t4_gnt_n1", 64'(o_if_gnt), 64'd0);
        cycle();
        chk("t4_ack_n2", 64'(o_halt_ack), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t4_no_fetch", 64'(o_if_gnt), 64'd0);
        end
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        cycle();
        chk("t4_dm_gnt", 64'(o_dm_gnt), 64'd1);
        dm_req = 1'b0;
        cycle();
        chk("t4_dm_rvalid", 64'(o_dm_rvalid), 64'd1);
        chk("t4_dm_rdata", 64'(o_dm_rdata), 64'(drv_rdata));
        chk("t4_ack_held", 64'(o_halt_ack), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
